// File: rtl/ex_mul_div_pkg.sv
// Shared definitions for the EX stage: opcode and result-class encodings,
// the reset level, and the divider FSM state type.
package ex_mul_div_pkg;

    typedef logic [7:0] alu_op_t;   // operation code bus
    typedef logic [2:0] alu_sel_t;  // result class bus

    localparam logic RST_ENABLE = 1'b0;

    localparam alu_op_t EXE_NOP_OP   = 8'b0000_0000;
    localparam alu_op_t EXE_AND_OP   = 8'b0010_0100;
    localparam alu_op_t EXE_OR_OP    = 8'b0010_0101;
    localparam alu_op_t EXE_XOR_OP   = 8'b0010_0110;
    localparam alu_op_t EXE_NOR_OP   = 8'b0010_0111;
    localparam alu_op_t EXE_SLL_OP   = 8'b0111_1100;
    localparam alu_op_t EXE_SRL_OP   = 8'b0000_0010;
    localparam alu_op_t EXE_SRA_OP   = 8'b0000_0011;
    localparam alu_op_t EXE_MFHI_OP  = 8'b0001_0000;
    localparam alu_op_t EXE_MTHI_OP  = 8'b0001_0001;
    localparam alu_op_t EXE_MFLO_OP  = 8'b0001_0010;
    localparam alu_op_t EXE_MTLO_OP  = 8'b0001_0011;
    localparam alu_op_t EXE_SLT_OP   = 8'b0010_1010;
    localparam alu_op_t EXE_SLTU_OP  = 8'b0010_1011;
    localparam alu_op_t EXE_ADD_OP   = 8'b0010_0000;
    localparam alu_op_t EXE_ADDU_OP  = 8'b0010_0001;
    localparam alu_op_t EXE_SUB_OP   = 8'b0010_0010;
    localparam alu_op_t EXE_SUBU_OP  = 8'b0010_0011;
    localparam alu_op_t EXE_MULT_OP  = 8'b0001_1000;
    localparam alu_op_t EXE_MULTU_OP = 8'b0001_1001;
    localparam alu_op_t EXE_DIV_OP   = 8'b0001_1010;
    localparam alu_op_t EXE_DIVU_OP  = 8'b0001_1011;

    localparam alu_sel_t EXE_RES_NOP   = 3'b000;
    localparam alu_sel_t EXE_RES_LOGIC = 3'b001;
    localparam alu_sel_t EXE_RES_SHIFT = 3'b010;
    localparam alu_sel_t EXE_RES_MOVE  = 3'b011;
    localparam alu_sel_t EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_mul_div_if.sv
// EX-stage bus: id_ex side drives the instruction fields and pipeline
// control, the EX stage returns the writeback fields, HI/LO and stall request.
interface ex_mul_div_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    import ex_mul_div_pkg::*;

    alu_op_t               aluop_i;
    alu_sel_t              alusel_i;
    logic [DATA_W-1:0]     reg1_i;
    logic [DATA_W-1:0]     reg2_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic                  stall_i;
    logic                  flush_i;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [DATA_W-1:0]     wdata_o;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic                  stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i, flush_i,
        input  wd_o, wreg_o, wdata_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i, flush_i,
        output wd_o, wreg_o, wdata_o, hi_o, lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider: IDLE -> BUSY (DATA_W cycles) -> DONE -> IDLE.
// Signed divides run on magnitudes and fix signs on the way out.
// Divide by zero skips BUSY and yields quotient all-ones, remainder = dividend.
module ex_div
    import ex_mul_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_signed,
    input  logic [DATA_W-1:0]   opdata1,
    input  logic [DATA_W-1:0]   opdata2,
    input  logic                annul,
    input  logic                stall,
    output logic [2*DATA_W-1:0] result,
    output logic                ready
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int M     = DATA_W - 1;

    div_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] divisor, rem, quo, mag1, mag2;
    logic              neg_q, neg_r;
    logic [DATA_W:0]   partial, trial;

    assign mag1    = (is_signed && opdata1[M]) ? (~opdata1 + 1'b1) : opdata1;
    assign mag2    = (is_signed && opdata2[M]) ? (~opdata2 + 1'b1) : opdata2;
    // Next dividend bit shifted into the partial remainder, then trial subtract.
    assign partial = {rem, quo[M]};
    assign trial   = partial - {1'b0, divisor};

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) state <= DIV_IDLE;
        else                   state <= state_nxt;
    end

    // Next-state: annul wins everywhere, stall freezes BUSY/DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start && !annul)
                          state_nxt = (opdata2 == '0) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (annul)
                          state_nxt = DIV_IDLE;
                      else if (!stall && cnt == CNT_W'(DATA_W - 1))
                          state_nxt = DIV_DONE;
            DIV_DONE: if (annul || !stall)
                          state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // Operand capture on start, one quotient bit per unstalled BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt     <= '0;
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (state == DIV_IDLE) begin
            if (start && !annul) begin
                cnt <= '0;
                if (opdata2 == '0) begin
                    quo   <= '1;
                    rem   <= opdata1;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else begin
                    divisor <= mag2;
                    quo     <= mag1;
                    rem     <= '0;
                    neg_q   <= is_signed && (opdata1[M] ^ opdata2[M]);
                    neg_r   <= is_signed && opdata1[M];
                end
            end
        end else if (state == DIV_BUSY && !stall && !annul) begin
            cnt <= cnt + 1'b1;
            if (!trial[DATA_W]) begin
                rem <= trial[DATA_W-1:0];
                quo <= {quo[M-1:0], 1'b1};
            end else begin
                rem <= partial[DATA_W-1:0];
                quo <= {quo[M-1:0], 1'b0};
            end
        end
    end

    assign result = {neg_r ? (~rem + 1'b1) : rem, neg_q ? (~quo + 1'b1) : quo};
    assign ready  = (state == DIV_DONE);

endmodule

// File: rtl/ex_mul_div.sv
// Execute stage: logic, shift, arithmetic and HI/LO moves are combinational;
// MULT/MULTU and moves-to update HI/LO on the clock edge.
// Optional iterative divider enabled by defining EX_DIV_EN; without it
// DIV/DIVU are NOPs and stallreq_o is tied low.
module ex_mul_div
    import ex_mul_div_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic         clk,
    input logic         rst,
    ex_mul_div_if.slave bus
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int M    = DATA_W - 1;

    logic [DATA_W-1:0]     r1, r2, hi, lo, res, sum, diff;
    logic [SH_W-1:0]       shamt;
    logic [2*DATA_W-1:0]   prod_s, prod_u, div_result;
    logic                  ov_add, ov_sub, wreg, div_ready;
    logic [REG_ADDR_W-1:0] wd;

    assign r1     = bus.reg1_i;
    assign r2     = bus.reg2_i;
    assign shamt  = r1[SH_W-1:0];
    assign sum    = r1 + r2;
    assign diff   = r1 - r2;
    assign ov_add = (r1[M] == r2[M]) && (sum[M] != r1[M]);
    assign ov_sub = (r1[M] != r2[M]) && (diff[M] != r1[M]);
    // Sign-extended operands: the low 2*DATA_W bits of the product are exact.
    assign prod_s = {{DATA_W{r1[M]}}, r1} * {{DATA_W{r2[M]}}, r2};
    assign prod_u = {{DATA_W{1'b0}}, r1} * {{DATA_W{1'b0}}, r2};

    // Result mux: each class decodes its own ops, anything unrecognised is zero.
    always_comb begin
        res = '0;
        case (bus.alusel_i)
            EXE_RES_LOGIC: case (bus.aluop_i)
                EXE_OR_OP:  res = r1 | r2;
                EXE_AND_OP: res = r1 & r2;
                EXE_XOR_OP: res = r1 ^ r2;
                EXE_NOR_OP: res = ~(r1 | r2);
                default:    res = '0;
            endcase
            EXE_RES_SHIFT: case (bus.aluop_i)
                EXE_SLL_OP: res = r2 << shamt;
                EXE_SRL_OP: res = r2 >> shamt;
                EXE_SRA_OP: res = $signed(r2) >>> shamt;
                default:    res = '0;
            endcase
            EXE_RES_ARITH: case (bus.aluop_i)
                EXE_ADD_OP, EXE_ADDU_OP: res = sum;
                EXE_SUB_OP, EXE_SUBU_OP: res = diff;
                EXE_SLT_OP:  res = {{M{1'b0}}, $signed(r1) < $signed(r2)};
                EXE_SLTU_OP: res = {{M{1'b0}}, r1 < r2};
                default:     res = '0;
            endcase
            EXE_RES_MOVE: case (bus.aluop_i)
                EXE_MFHI_OP: res = hi;
                EXE_MFLO_OP: res = lo;
                default:     res = '0;
            endcase
            default: res = '0;
        endcase
    end

    // Write enable: suppressed on signed overflow and for HI/LO-only ops.
    always_comb begin
        wreg = bus.wreg_i;
        case (bus.aluop_i)
            EXE_ADD_OP: if (ov_add) wreg = 1'b0;
            EXE_SUB_OP: if (ov_sub) wreg = 1'b0;
            EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP: wreg = 1'b0;
            default: ;
        endcase
    end

`ifdef EX_DIV_EN
    logic is_div;
    assign is_div = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);

    ex_div #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div),
        .is_signed (bus.aluop_i == EXE_DIV_OP),
        .opdata1   (r1),
        .opdata2   (r2),
        .annul     (bus.flush_i),
        .stall     (bus.stall_i),
        .result    (div_result),
        .ready     (div_ready)
    );

    // Hold upstream from the start cycle until the divider reaches DONE.
    assign bus.stallreq_o = (rst != RST_ENABLE) && is_div && !div_ready && !bus.flush_i;
`else
    assign div_ready      = 1'b0;
    assign div_result     = '0;
    assign bus.stallreq_o = 1'b0;
`endif

    // HI/LO: divider result has priority; stalled or flushed cycles write nothing.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi <= '0;
            lo <= '0;
        end else if (!bus.stall_i && !bus.flush_i) begin
            if (div_ready) begin
                {hi, lo} <= div_result;
            end else begin
                case (bus.aluop_i)
                    EXE_MULT_OP:  {hi, lo} <= prod_s;
                    EXE_MULTU_OP: {hi, lo} <= prod_u;
                    EXE_MTHI_OP:  hi <= r1;
                    EXE_MTLO_OP:  lo <= r1;
                    default: ;
                endcase
            end
        end
    end

    assign wd          = (rst == RST_ENABLE) ? '0 : bus.wd_i;
    assign bus.wd_o    = wd;
    assign bus.wreg_o  = (rst == RST_ENABLE) ? 1'b0 : wreg;
    assign bus.wdata_o = (rst == RST_ENABLE) ? '0 : res;
    assign bus.hi_o    = hi;
    assign bus.lo_o    = lo;

endmodule

// File: tb/tb_ex_mul_div.sv
// Bench for ex_mul_div at DATA_W=32: directed cases plus randomized ops
// checked against an arithmetic reference model; divider cases are built
// only when EX_DIV_EN is defined, otherwise DIV is checked as a NOP.
module tb_ex_mul_div;
    import ex_mul_div_pkg::*;

    localparam int W = 32;
    localparam int A = 5;
    localparam int NOPS = 22;

    localparam alu_op_t OPS [NOPS] = '{
        EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP,
        EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
        EXE_ADD_OP, EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP,
        EXE_MFHI_OP, EXE_MFLO_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_MULT_OP, EXE_MULTU_OP,
        8'hFF, EXE_OR_OP, EXE_AND_OP};
    localparam alu_sel_t SELS [NOPS] = '{
        EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC,
        EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_SHIFT,
        EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH,
        EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_NOP, EXE_RES_NOP, EXE_RES_NOP, EXE_RES_NOP,
        EXE_RES_LOGIC, 3'b111, EXE_RES_ARITH};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    ex_mul_div_if #(.DATA_W(W), .REG_ADDR_W(A)) bus ();
    ex_mul_div #(.DATA_W(W), .REG_ADDR_W(A)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_op_t op, input alu_sel_t sel, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = a;
        bus.reg2_i   = b;
        bus.wd_i     = A'($urandom_range(1, 31));
        bus.wreg_i   = 1'b1;
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Reference for the combinational outputs, from plain integer arithmetic.
    function automatic void ref_ex(input alu_op_t op, input alu_sel_t sel, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic wr, input logic [W-1:0] hi,
                                   input logic [W-1:0] lo, output logic [W-1:0] wd, output logic we);
        longint s1, s2, t;
        int sh;
        s1 = longint'($signed(a));
        s2 = longint'($signed(b));
        sh = int'(a % W);
        wd = '0;
        we = wr;
        case (sel)
            EXE_RES_LOGIC: case (op)
                EXE_OR_OP:  wd = a | b;
                EXE_AND_OP: wd = a & b;
                EXE_XOR_OP: wd = a ^ b;
                EXE_NOR_OP: wd = ~(a | b);
                default: ;
            endcase
            EXE_RES_SHIFT: case (op)
                EXE_SLL_OP: wd = b << sh;
                EXE_SRL_OP: wd = b >> sh;
                EXE_SRA_OP: begin t = s2 >>> sh; wd = t[W-1:0]; end
                default: ;
            endcase
            EXE_RES_ARITH: case (op)
                EXE_ADD_OP: begin
                    t = s1 + s2; wd = t[W-1:0];
                    if (t != longint'($signed(t[W-1:0]))) we = 1'b0;
                end
                EXE_SUB_OP: begin
                    t = s1 - s2; wd = t[W-1:0];
                    if (t != longint'($signed(t[W-1:0]))) we = 1'b0;
                end
                EXE_ADDU_OP: wd = a + b;
                EXE_SUBU_OP: wd = a - b;
                EXE_SLT_OP:  wd[0] = (s1 < s2);
                EXE_SLTU_OP: wd[0] = (a < b);
                default: ;
            endcase
            EXE_RES_MOVE: case (op)
                EXE_MFHI_OP: wd = hi;
                EXE_MFLO_OP: wd = lo;
                default: ;
            endcase
            default: ;
        endcase
        if (op == EXE_MULT_OP || op == EXE_MULTU_OP || op == EXE_DIV_OP || op == EXE_DIVU_OP)
            we = 1'b0;
    endfunction

    // HI/LO model for one unstalled, unflushed edge.
    task automatic model_edge(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        logic [63:0] u;
        case (op)
            EXE_MULT_OP:  begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
            EXE_MULTU_OP: begin u = 64'(a) * 64'(b); {m_hi, m_lo} = u; end
            EXE_MTHI_OP:  m_hi = a;
            EXE_MTLO_OP:  m_lo = a;
            default: ;
        endcase
    endtask

    task automatic check_ex(input string tag);
        logic [W-1:0] wd;
        logic we;
        ref_ex(bus.aluop_i, bus.alusel_i, bus.reg1_i, bus.reg2_i, bus.wreg_i, m_hi, m_lo, wd, we);
        check({tag, ".wdata"}, 64'(bus.wdata_o), 64'(wd));
        check({tag, ".wreg"}, 64'(bus.wreg_o), 64'(we));
        check({tag, ".wd"}, 64'(bus.wd_o), 64'(bus.wd_i));
    endtask

    task automatic check_hilo(input string tag);
        check({tag, ".hi"}, 64'(bus.hi_o), 64'(m_hi));
        check({tag, ".lo"}, 64'(bus.lo_o), 64'(m_lo));
    endtask

`ifdef EX_DIV_EN
    task automatic div_model(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint q, r;
        logic [63:0] uq, ur;
        if (b == '0) begin
            m_lo = '1;
            m_hi = a;
        end else if (op == EXE_DIV_OP) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            m_lo = q[W-1:0];
            m_hi = r[W-1:0];
        end else begin
            uq = 64'(a) / 64'(b);
            ur = 64'(a) % 64'(b);
            m_lo = uq[W-1:0];
            m_hi = ur[W-1:0];
        end
    endtask

    // Present a divide, count stall-request cycles (optionally stalling mid-BUSY),
    // retire it in the DONE cycle and compare HI/LO.
    task automatic run_div(input string tag, input alu_op_t op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int stall_at, input int stall_len);
        int n = 0;
        int exp_n;
        exp_n = (b == '0) ? 1 : W + 1 + stall_len;
        drive(op, EXE_RES_NOP, a, b);
        check({tag, ".wreg"}, 64'(bus.wreg_o), 64'd0);
        check({tag, ".wdata"}, 64'(bus.wdata_o), 64'd0);
        while (bus.stallreq_o === 1'b1 && n < 200) begin
            if (stall_len > 0 && n == stall_at) bus.stall_i = 1'b1;
            if (stall_len > 0 && n == stall_at + stall_len) bus.stall_i = 1'b0;
            tick();
            n++;
        end
        bus.stall_i = 1'b0;
        check({tag, ".stall_cycles"}, 64'(n), 64'(exp_n));
        drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0);
        tick();
        div_model(op, a, b);
        check_hilo(tag);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;

        // Reset: outputs forced low, HI/LO cleared, MTHI ignored.
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'hF0F0_0000, 32'h0000_FFFF);
        tick();
        check("rst.wdata", 64'(bus.wdata_o), 64'd0);
        check("rst.wreg", 64'(bus.wreg_o), 64'd0);
        check("rst.wd", 64'(bus.wd_o), 64'd0);
        check("rst.stallreq", 64'(bus.stallreq_o), 64'd0);
        drive(EXE_MTHI_OP, EXE_RES_NOP, 32'h1234_5678, 32'h0);
        tick();
        check_hilo("rst");
        rst = 1'b1;

        // Directed single-cycle cases.
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'hF0F0_0000, 32'h0000_FFFF);
        check("or.wdata", 64'(bus.wdata_o), 64'hF0F0_FFFF);
        check("or.wreg", 64'(bus.wreg_o), 64'd1);
        drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000);
        check("sra.wdata", 64'(bus.wdata_o), 64'hF800_0000);
        check("sra.wreg", 64'(bus.wreg_o), 64'd1);
        drive(EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'd1);
        check("add_ov.wreg", 64'(bus.wreg_o), 64'd0);
        check("add_ov.wdata", 64'(bus.wdata_o), 64'h8000_0000);
        drive(EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'd1);
        check("addu.wdata", 64'(bus.wdata_o), 64'h8000_0000);
        check("addu.wreg", 64'(bus.wreg_o), 64'd1);

        // Multiplies, then MFHI back-to-back reads the fresh register.
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd2);
        check("mult.wreg", 64'(bus.wreg_o), 64'd0);
        tick();
        check("mult.hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
        check("mult.lo", 64'(bus.lo_o), 64'hFFFF_FFFE);
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFFE;
        drive(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd2);
        tick();
        check("multu.hi", 64'(bus.hi_o), 64'h1);
        check("multu.lo", 64'(bus.lo_o), 64'hFFFF_FFFE);
        m_hi = 32'h1;
        drive(EXE_MFHI_OP, EXE_RES_MOVE, '0, '0);
        check("mfhi.wdata", 64'(bus.wdata_o), 64'h1);

        // Stall and flush each block a HI/LO write.
        bus.stall_i = 1'b1;
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'd3, 32'd5);
        tick();
        check_hilo("mult_stalled");
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b1;
        drive(EXE_MTLO_OP, EXE_RES_NOP, 32'hDEAD_BEEF, 32'd0);
        tick();
        check_hilo("mtlo_flushed");
        bus.flush_i = 1'b0;

        // Randomized single-cycle and HI/LO ops against the model.
        for (int i = 0; i < 80; i++) begin
            int k;
            logic st, fl;
            k = $urandom_range(0, NOPS - 1);
            drive(OPS[k], SELS[k], pick(), pick());
            bus.wreg_i = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 7) == 0);
            bus.stall_i = st;
            bus.flush_i = fl;
            #1;
            check_ex("rand");
            check("rand.stallreq", 64'(bus.stallreq_o), 64'd0);
            tick();
            if (!st && !fl) model_edge(OPS[k], bus.reg1_i, bus.reg2_i);
            check_hilo("rand");
        end
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;

`ifdef EX_DIV_EN
        run_div("div_neg", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_neg.lo_lit", 64'(bus.lo_o), 64'hFFFF_FFFD);
        check("div_neg.hi_lit", 64'(bus.hi_o), 64'hFFFF_FFFF);
        run_div("div0", EXE_DIV_OP, 32'd5, 32'd0, 0, 0);
        check("div0.lo_lit", 64'(bus.lo_o), 64'hFFFF_FFFF);

        // Flush in cycle 10 of a divide: request drops, HI/LO untouched.
        drive(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        check("flush.pre_stallreq", 64'(bus.stallreq_o), 64'd1);
        bus.flush_i = 1'b1;
        #1;
        check("flush.stallreq", 64'(bus.stallreq_o), 64'd0);
        tick();
        bus.flush_i = 1'b0;
        drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0);
        check("flush.after_stallreq", 64'(bus.stallreq_o), 64'd0);
        tick();
        tick();
        check_hilo("flush");
        run_div("divu", EXE_DIVU_OP, 32'd100, 32'd7, 0, 0);
        check("divu.lo_lit", 64'(bus.lo_o), 64'd14);
        check("divu.hi_lit", 64'(bus.hi_o), 64'd2);

        // Downstream stall freezes BUSY for four cycles.
        run_div("div_stall", EXE_DIV_OP, 32'h8000_0001, 32'hFFFF_FFFD, 5, 4);

        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a, b;
            a = pick();
            b = pick();
            if (b == '0) b = 32'd3;
            run_div("div_rand", (i % 2 == 0) ? EXE_DIV_OP : EXE_DIVU_OP, a, b, 0, 0);
        end

        // Reset mid-divide: everything low, HI/LO cleared, FSM idle afterwards.
        drive(EXE_DIV_OP, EXE_RES_NOP, 32'd50, 32'd3);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        #1;
        check("rst_div.stallreq", 64'(bus.stallreq_o), 64'd0);
        check("rst_div.wd", 64'(bus.wd_o), 64'd0);
        check("rst_div.wdata", 64'(bus.wdata_o), 64'd0);
        tick();
        m_hi = '0;
        m_lo = '0;
        check_hilo("rst_div");
        drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0);
        rst = 1'b1;
        tick();
        check("rst_div.idle_stallreq", 64'(bus.stallreq_o), 64'd0);
        run_div("rst_divu", EXE_DIVU_OP, 32'd100, 32'd7, 0, 0);
`else
        // Divider not built: DIV/DIVU are NOPs.
        drive(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2);
        check("nodiv.stallreq", 64'(bus.stallreq_o), 64'd0);
        check("nodiv.wreg", 64'(bus.wreg_o), 64'd0);
        check("nodiv.wdata", 64'(bus.wdata_o), 64'd0);
        tick();
        check_hilo("nodiv");
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
        check("nodivu.stallreq", 64'(bus.stallreq_o), 64'd0);
        tick();
        tick();
        check_hilo("nodivu");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
